// File: rtl/liteeth_sram_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module : liteeth_sram_fifo_pkg
// Desc   : Shared sizing defaults and 42-bit stream word layout for the SRAM FIFO.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package liteeth_sram_fifo_pkg;

    localparam int FIFO_BITS         = 42;
    localparam int FIFO_DEPTH        = 32;
    localparam int FIFO_ADDR_WIDTH   = 5;
    localparam int FIFO_AFULL_THRESH = 30;

    localparam int FLD_DATA_LSB = 0;
    localparam int FLD_DATA_MSB = 31;
    localparam int FLD_BE_LSB   = 32;
    localparam int FLD_BE_MSB   = 35;
    localparam int FLD_LAST     = 36;
    localparam int FLD_SB_LSB   = 37;
    localparam int FLD_SB_MSB   = 41;

    function automatic logic [FIFO_BITS-1:0] pack_word(
        input logic [31:0] data,
        input logic [3:0]  be,
        input logic        last,
        input logic [4:0]  sb
    );
        return {sb, last, be, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/liteeth_fifo_out_buf.sv
//------------------------------------------------------------------------------
// Module : liteeth_fifo_out_buf
// Desc   : Two-entry register FIFO holding SRAM read data ahead of the source port.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module liteeth_fifo_out_buf
    import liteeth_sram_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_idx;
    logic             r_rd_idx;
    logic [1:0]       r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_idx <= ~r_wr_idx;
            end
            if (w_do_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_data  = r_mem[r_rd_idx];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/liteeth_sram_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module : liteeth_sram_fifo_ctrl
// Desc   : FWFT FIFO controller around a 1R1W SRAM macro; optional level/almost_full
//          outputs enabled by LITEETH_SRAM_FIFO_LEVEL_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module liteeth_sram_fifo_ctrl
    import liteeth_sram_fifo_pkg::*;
#(
    parameter int BITS         = FIFO_BITS,
    parameter int DEPTH        = FIFO_DEPTH,
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic [BITS-1:0]       sink_data,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [BITS-1:0]       source_data,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [BITS-1:0]       sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [BITS-1:0]       sram_dout1,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full
);

    localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_PTR_ONE    = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic                r_inflight;
    logic [ADDR_WIDTH:0] w_sram_count;
    logic                w_full;
    logic                w_wr_en;
    logic                w_pop;
    logic                w_issue;
    logic [1:0]          w_ob_count;
    logic [2:0]          w_ob_after;

    // Pointers carry one extra bit so full (DEPTH) and empty (0) are distinct.
    assign w_sram_count = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_sram_count == c_FULL_COUNT);

    assign sink_ready = !sys_rst && !w_full;
    assign w_wr_en    = sink_valid && sink_ready;
    assign sram_csb0  = !w_wr_en;
    assign sram_web0  = !w_wr_en;
    assign sram_addr0 = r_wr_ptr[ADDR_WIDTH-1:0];
    assign sram_din0  = sink_data;

    assign source_valid = (w_ob_count != 2'd0);
    assign w_pop        = source_valid && source_ready;

    // Reserve an output-buffer slot for every read before issuing it.
    assign w_ob_after = {1'b0, w_ob_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (w_sram_count != '0) && (w_ob_after < 3'd2);
    assign sram_csb1  = !w_issue;
    assign sram_addr1 = r_rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_inflight <= w_issue;
        end
    end

    liteeth_fifo_out_buf #(
        .WIDTH (BITS)
    ) u_out_buf (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_push  (r_inflight),
        .i_data  (sram_dout1),
        .i_pop   (w_pop),
        .o_data  (source_data),
        .o_count (w_ob_count)
    );

`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] c_AFULL = (ADDR_WIDTH+1)'(AFULL_THRESH);

    logic [ADDR_WIDTH:0] w_level;

    assign w_level     = w_sram_count
                       + {{ADDR_WIDTH{1'b0}}, r_inflight}
                       + {{(ADDR_WIDTH-1){1'b0}}, w_ob_count};
    assign level       = w_level;
    assign almost_full = (w_level >= c_AFULL);
`else
    logic [31:0] w_unused_thresh;

    assign w_unused_thresh = AFULL_THRESH;
    assign level           = '0;
    assign almost_full     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_liteeth_sram_fifo_ctrl
// Desc   : Directed bench for liteeth_sram_fifo_ctrl with a behavioural SRAM macro.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_liteeth_sram_fifo_ctrl;
    import liteeth_sram_fifo_pkg::*;

    logic        clk;
    logic        sys_rst;
    logic        sink_valid;
    logic        sink_ready;
    logic [41:0] sink_data;
    logic        source_valid;
    logic        source_ready;
    logic [41:0] source_data;
    logic        sram_csb0;
    logic        sram_web0;
    logic [4:0]  sram_addr0;
    logic [41:0] sram_din0;
    logic        sram_csb1;
    logic [4:0]  sram_addr1;
    logic [41:0] sram_dout1;
    logic [5:0]  level;
    logic        almost_full;

    logic [41:0] mem [0:31];
    logic [41:0] q[$];
    int          total;
    int          bad;

    liteeth_sram_fifo_ctrl dut (
        .sys_clk      (clk),
        .sys_rst      (sys_rst),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_data    (sink_data),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_data  (source_data),
        .sram_csb0    (sram_csb0),
        .sram_web0    (sram_web0),
        .sram_addr0   (sram_addr0),
        .sram_din0    (sram_din0),
        .sram_csb1    (sram_csb1),
        .sram_addr1   (sram_addr1),
        .sram_dout1   (sram_dout1),
        .level        (level),
        .almost_full  (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_csb0 && !sram_web0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    function automatic logic [41:0] mkword(input int i);
        return pack_word(32'h1000_0000 + 32'(i) * 32'h0001_0003, 4'(i), 1'(i), 5'(i * 3));
    endfunction

    function automatic logic [5:0] exp_level(input int n);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        return 6'(n);
`else
        return 6'd0;
`endif
    endfunction

    function automatic logic exp_afull(input int n);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        return (n >= 30);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic sv, input logic [41:0] sd, input logic sr);
        @(negedge clk);
        sink_valid   = sv;
        sink_data    = sd;
        source_ready = sr;
        #1;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1; sink_valid = 1'b0; sink_data = '0; source_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (sink_ready !== 1'b0) begin bad++; $display("FAIL rst_sink_ready: got %b want 0", sink_ready); end
        total++; if (source_valid !== 1'b0) begin bad++; $display("FAIL rst_source_valid: got %b want 0", source_valid); end
        total++; if ({sram_csb0, sram_web0, sram_csb1} !== 3'b111) begin bad++; $display("FAIL rst_sram_ctl: got %b want 111", {sram_csb0, sram_web0, sram_csb1}); end
        total++; if (level !== 6'd0 || almost_full !== 1'b0) begin bad++; $display("FAIL rst_level: got %0d/%b want 0/0", level, almost_full); end
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        total++; if (sink_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", sink_ready); end
    endtask

    task automatic test_single;
        logic [41:0] w;
        w = 42'h2AA_5555_5555;
        drive(1'b1, w, 1'b1);
        total++; if ({sram_csb0, sram_web0} !== 2'b00 || sram_addr0 !== 5'd0 || sram_din0 !== w) begin
            bad++; $display("FAIL single_write: got csb/web=%b addr=%0d din=%h want 00 0 %h", {sram_csb0, sram_web0}, sram_addr0, sram_din0, w);
        end
        if (sink_ready) q.push_back(w);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, '0, 1'b1);
            if (k == 1) begin
                total++; if (sram_csb1 !== 1'b0 || sram_addr1 !== 5'd0) begin bad++; $display("FAIL single_issue: got csb1=%b addr1=%0d want 0 0", sram_csb1, sram_addr1); end
            end
            if (k < 3) begin
                total++; if (source_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid_c%0d: got %b want 0", k, source_valid); end
            end else begin
                total++; if (source_valid !== 1'b1 || source_data !== w) begin bad++; $display("FAIL single_out: got %b %h want 1 %h", source_valid, source_data, w); end
                if (source_valid && q.size() > 0) void'(q.pop_front());
            end
        end
        drive(1'b0, '0, 1'b1);
        total++; if (source_valid !== 1'b0 || level !== exp_level(0)) begin bad++; $display("FAIL single_after_pop: got %b lvl=%0d want 0 %0d", source_valid, level, exp_level(0)); end
    endtask

    task automatic test_fill;
        int n_acc;
        n_acc = 0;
        for (int c = 0; c < 60 && n_acc < 34; c++) begin
            drive(1'b1, mkword(n_acc), 1'b0);
            total++; if (sink_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d: got %b want 1", n_acc, sink_ready); end
            total++; if (level !== exp_level(q.size()) || almost_full !== exp_afull(q.size())) begin
                bad++; $display("FAIL fill_level_%0d: got %0d/%b want %0d/%b", n_acc, level, almost_full, exp_level(q.size()), exp_afull(q.size()));
            end
            if (sink_ready) begin q.push_back(sink_data); n_acc++; end
        end
        total++; if (n_acc != 34) begin bad++; $display("FAIL fill_accepted: got %0d want 34", n_acc); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, mkword(99), 1'b0);
            total++; if (sink_ready !== 1'b0) begin bad++; $display("FAIL full_refuse_%0d: got %b want 0", k, sink_ready); end
            total++; if (level !== exp_level(34) || almost_full !== exp_afull(34)) begin bad++; $display("FAIL full_level: got %0d/%b want %0d/%b", level, almost_full, exp_level(34), exp_afull(34)); end
            if (sink_ready) q.push_back(sink_data);
        end
    endtask

    task automatic test_drain;
        int steps;
        drive(1'b0, '0, 1'b1);
        total++; if (source_valid !== 1'b1 || source_data !== mkword(0)) begin bad++; $display("FAIL drain_first: got %b %h want 1 %h", source_valid, source_data, mkword(0)); end
        total++; if (sink_ready !== 1'b0) begin bad++; $display("FAIL drain_ready_same: got %b want 0", sink_ready); end
        if (source_valid && q.size() > 0) void'(q.pop_front());
        drive(1'b0, '0, 1'b0);
        total++; if (sink_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_next: got %b want 1", sink_ready); end
        total++; if (level !== exp_level(33)) begin bad++; $display("FAIL drain_level: got %0d want %0d", level, exp_level(33)); end
        steps = 0;
        while (q.size() > 0 && steps < 100) begin
            drive(1'b0, '0, 1'b1);
            if (source_valid) begin
                total++; if (source_data !== q[0]) begin bad++; $display("FAIL drain_order: got %h want %h", source_data, q[0]); end
                void'(q.pop_front());
            end
            steps++;
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL drain_timeout: left %0d want 0", q.size()); end
        drive(1'b0, '0, 1'b1);
        total++; if (source_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", source_valid); end
    endtask

    task automatic test_stream;
        int sent, got, gaps;
        bit started;
        sent = 0; got = 0; gaps = 0; started = 0;
        for (int c = 0; c < 400 && got < 100; c++) begin
            drive(sent < 100, mkword(200 + sent), 1'b1);
            if (source_valid) begin
                started = 1;
                total++; if (q.size() == 0 || source_data !== q[0]) begin bad++; $display("FAIL stream_data_%0d: got %h", got, source_data); end
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end else if (started) begin
                gaps++;
            end
            if (sink_valid && sink_ready) begin q.push_back(sink_data); sent++; end
        end
        total++; if (got != 100) begin bad++; $display("FAIL stream_count: got %0d want 100", got); end
        total++; if (gaps != 0) begin bad++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    endtask

    task automatic test_random;
        int sent, got, lvl_err, occ_err;
        sent = 0; got = 0; lvl_err = 0; occ_err = 0;
        for (int c = 0; c < 3000 && got < 200; c++) begin
            drive((sent < 200) && ($urandom_range(3) != 0), mkword(500 + sent), 1'($urandom_range(1)));
            if (int'(dut.r_inflight) + int'(dut.w_ob_count) > 2) occ_err++;
            if (level !== exp_level(q.size())) lvl_err++;
            if (source_valid && source_ready) begin
                total++; if (q.size() == 0 || source_data !== q[0]) begin bad++; $display("FAIL random_data_%0d: got %h", got, source_data); end
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end
            if (sink_valid && sink_ready) begin q.push_back(sink_data); sent++; end
        end
        total++; if (got != 200) begin bad++; $display("FAIL random_count: got %0d want 200", got); end
        total++; if (occ_err != 0) begin bad++; $display("FAIL random_occupancy: got %0d violations want 0", occ_err); end
        total++; if (lvl_err != 0) begin bad++; $display("FAIL random_level: got %0d errors want 0", lvl_err); end
    endtask

    task automatic test_reset_midflight;
        int n_acc;
        logic [41:0] w2;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, mkword(900 + i), 1'b0);
            if (sink_ready) begin q.push_back(sink_data); n_acc++; end
        end
        total++; if (n_acc != 10) begin bad++; $display("FAIL mid_accept: got %0d want 10", n_acc); end
        drive(1'b0, '0, 1'b1);
        total++; if (source_valid !== 1'b1 || source_data !== mkword(900)) begin bad++; $display("FAIL mid_pop: got %b %h want 1 %h", source_valid, source_data, mkword(900)); end
        drive(1'b0, '0, 1'b0);
        total++; if (dut.r_inflight !== 1'b1) begin bad++; $display("FAIL mid_inflight: got %b want 1", dut.r_inflight); end
        sys_rst = 1'b1;
        #1;
        total++; if (sink_ready !== 1'b0 || source_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_hs: got %b %b want 0 0", sink_ready, source_valid); end
        total++; if ({sram_csb0, sram_web0, sram_csb1} !== 3'b111) begin bad++; $display("FAIL mid_rst_sram: got %b want 111", {sram_csb0, sram_web0, sram_csb1}); end
        total++; if (level !== 6'd0 || almost_full !== 1'b0) begin bad++; $display("FAIL mid_rst_level: got %0d/%b want 0/0", level, almost_full); end
        q.delete();
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        w2 = mkword(777);
        drive(1'b1, w2, 1'b1);
        total++; if (sink_ready !== 1'b1) begin bad++; $display("FAIL mid_after_ready: got %b want 1", sink_ready); end
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, '0, 1'b1);
            if (k < 3) begin
                total++; if (source_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_c%0d: got %b want 0", k, source_valid); end
            end else begin
                total++; if (source_valid !== 1'b1 || source_data !== w2) begin bad++; $display("FAIL mid_first_new: got %b %h want 1 %h", source_valid, source_data, w2); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_stream();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
